// File: rtl/des_pkg.sv
// Shared types and constants for the iterative DES round controller and
// the key-schedule shift lookup.
package des_pkg;

  localparam int NUM_ROUNDS  = 16;
  localparam int ROUND_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [1:0] shift_t;

  // C/D rotate amount per round. Decrypt rotates right and starts from the
  // K16 alignment, so its first round needs no shift.
  localparam shift_t ENC_SHIFT [NUM_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam shift_t DEC_SHIFT [NUM_ROUNDS] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic shift_t shift_lookup(input logic [ROUND_IDX_W-1:0] idx,
                                          input logic                   decrypt);
    return decrypt ? DEC_SHIFT[idx] : ENC_SHIFT[idx];
  endfunction

endpackage

// File: rtl/des_shift_sched.sv
// Combinational key-schedule lookup: rotate amount and direction for a
// given round index and operating mode.
module des_shift_sched
  import des_pkg::*;
(
  input  logic [ROUND_IDX_W-1:0] round_idx_i,
  input  logic                   mode_i,
  output logic [1:0]             shift_amt_o,
  output logic                   shift_dir_o
);

  always_comb begin
    shift_amt_o = shift_lookup(round_idx_i, mode_i);
    shift_dir_o = mode_i;
  end

endmodule

// File: rtl/des_round_ctrl.sv
// Sequencer for a shared DES round datapath: one 16-round encrypt/decrypt
// per accepted block, each round lasting SBOX_LAT+1 cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a block; load_en follows in_valid in the accept cycle
// ROUND | stepping rounds; round_en on the last phase of each round
// FINAL | one-cycle final_en, datapath captures FP(R16||L16)
// DONE  | result held with out_valid until out_ready
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int SBOX_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_decrypt,
  output logic                   load_en,
  output logic                   round_en,
  output logic [ROUND_IDX_W-1:0] round_idx,
  output logic [1:0]             shift_amt,
  output logic                   shift_dir,
  output logic                   final_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam logic [1:0]             PHASE_LAST = SBOX_LAT[1:0];
  localparam logic [ROUND_IDX_W-1:0] LAST_ROUND = ROUND_IDX_W'(NUM_ROUNDS - 1);

  state_e                   state_q, state_d;
  logic [ROUND_IDX_W-1:0]   round_idx_q, round_idx_d;
  logic [1:0]               phase_q, phase_d;
  logic                     mode_q, mode_d;

  logic                     load_c, round_c, final_c;
  logic [1:0]               sched_amt;
  logic                     sched_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      round_idx_q <= '0;
      phase_q     <= '0;
      mode_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    in_ready    = 1'b0;
    load_c      = 1'b0;
    round_c     = 1'b0;
    final_c     = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        load_c   = in_valid;
        if (in_valid) begin
          mode_d      = in_decrypt;
          round_idx_d = '0;
          phase_d     = '0;
          state_d     = ROUND;
        end
      end

      ROUND: begin
        if (phase_q == PHASE_LAST) begin
          round_c = 1'b1;
          phase_d = '0;
          if (round_idx_q == LAST_ROUND) begin
            state_d = FINAL;
          end else begin
            round_idx_d = round_idx_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end

      FINAL: begin
        final_c = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A cycle with rst high is being aborted, so keep the datapath untouched.
  assign load_en  = load_c  & ~rst;
  assign round_en = round_c & ~rst;
  assign final_en = final_c & ~rst;

  des_shift_sched u_shift_sched (
    .round_idx_i (round_idx_q),
    .mode_i      (mode_q),
    .shift_amt_o (sched_amt),
    .shift_dir_o (sched_dir)
  );

  assign round_idx = round_idx_q;
  assign shift_amt = (state_q == ROUND) ? sched_amt : 2'd0;
  assign shift_dir = sched_dir;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Directed plus randomized bench for des_round_ctrl at SBOX_LAT 0 and 2,
// checked against a cycle-offset reference model of the round schedule.
module tb_des_round_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid   [2];
  logic       in_decrypt [2];
  logic       out_ready  [2];
  logic       in_ready   [2];
  logic       load_en    [2];
  logic       round_en   [2];
  logic       final_en   [2];
  logic       out_valid  [2];
  logic       busy       [2];
  logic       shift_dir  [2];
  logic [3:0] round_idx  [2];
  logic [1:0] shift_amt  [2];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam int LAT [2] = '{0, 2};

  always @(posedge clk) cyc <= cyc + 1;

  des_round_ctrl #(.SBOX_LAT(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_decrypt(in_decrypt[0]),
    .load_en(load_en[0]), .round_en(round_en[0]), .round_idx(round_idx[0]),
    .shift_amt(shift_amt[0]), .shift_dir(shift_dir[0]), .final_en(final_en[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .busy(busy[0])
  );

  des_round_ctrl #(.SBOX_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_decrypt(in_decrypt[1]),
    .load_en(load_en[1]), .round_en(round_en[1]), .round_idx(round_idx[1]),
    .shift_amt(shift_amt[1]), .shift_dir(shift_dir[1]), .final_en(final_en[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .busy(busy[1])
  );

  // Reference: standard DES rotate schedule; decrypt's first round is a no-op.
  function automatic int exp_amt(input bit mode, input int idx);
    if (idx == 0) return mode ? 0 : 1;
    if (idx == 1 || idx == 8 || idx == 15) return 1;
    return 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int k);
    check("idle_ready", in_ready[k], 1);
    check("idle_busy", busy[k], 0);
    check("idle_out_valid", out_valid[k], 0);
    check("idle_round_en", round_en[k], 0);
    check("idle_final_en", final_en[k], 0);
    check("idle_shift_amt", shift_amt[k], 0);
  endtask

  // One full block on instance k, accept cycle included. in_valid stays high
  // throughout so any spurious second accept shows up as load_en.
  task automatic run_block(input int k, input bit mode, input bit toggle,
                           input int stall, input bit hold_after,
                           output int acc_cyc);
    int r;
    int sum;
    bit dm;
    bit exp_re;
    r   = LAT[k] + 1;
    sum = 0;
    dm  = mode;
    @(negedge clk);
    in_valid[k]   = 1'b1;
    in_decrypt[k] = mode;
    out_ready[k]  = 1'b0;
    #1;
    check("accept_ready", in_ready[k], 1);
    check("accept_load", load_en[k], 1);
    check("accept_busy", busy[k], 0);
    acc_cyc = cyc;
    for (int d = 1; d <= 16 * r + 1; d++) begin
      @(negedge clk);
      if (toggle) begin
        dm = ~dm;
        in_decrypt[k] = dm;
      end
      #1;
      exp_re = (d % r == 0) && (d <= 16 * r);
      check("load_quiet", load_en[k], 0);
      check("round_en", round_en[k], exp_re);
      check("final_en", final_en[k], d == 16 * r + 1);
      check("run_busy", busy[k], 1);
      check("run_ready", in_ready[k], 0);
      check("run_out_valid", out_valid[k], 0);
      check("shift_dir", shift_dir[k], mode);
      if (exp_re) begin
        check("round_idx", round_idx[k], d / r - 1);
        check("shift_amt", shift_amt[k], exp_amt(mode, d / r - 1));
        sum += int'(shift_amt[k]);
      end
      if (d == 16 * r + 1) check("final_shift_amt", shift_amt[k], 0);
    end
    check("shift_total", sum, mode ? 27 : 28);
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      out_ready[k] = (s == stall);
      #1;
      check("done_valid", out_valid[k], 1);
      check("done_ready", in_ready[k], 0);
      check("done_load", load_en[k], 0);
      check("done_busy", busy[k], 1);
    end
    if (!hold_after) begin
      @(negedge clk);
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b0;
      #1;
      check_idle(k);
      check("idle_load", load_en[k], 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    int k;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]   = 1'b0;
      in_decrypt[i] = 1'b0;
      out_ready[i]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", busy[i], 0);
      check("rst_round_idx", round_idx[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_idle(i);
      check("rst_round_idx", round_idx[i], 0);
      check("rst_shift_dir", shift_dir[i], 0);
      check("rst_load", load_en[i], 0);
    end

    // Encrypt at SBOX_LAT=0, decrypt at SBOX_LAT=2
    run_block(0, 1'b0, 1'b0, 0, 1'b0, a0);
    run_block(1, 1'b1, 1'b0, 0, 1'b0, a0);

    // Backpressure, then back-to-back with in_valid held high
    run_block(0, 1'(($urandom % 2)), 1'b0, 10, 1'b1, a0);
    run_block(0, 1'(($urandom % 2)), 1'b0, 0, 1'b1, a1);
    run_block(0, 1'(($urandom % 2)), 1'b0, 0, 1'b0, a2);
    check("stall_spacing", a1 - a0, 16 * 1 + 3 + 10);
    check("b2b_spacing", a2 - a1, 16 * 1 + 3);

    // Mode toggling mid-operation
    run_block(1, 1'b0, 1'b1, 0, 1'b0, a0);
    run_block(1, 1'b1, 1'b1, 0, 1'b1, a0);
    run_block(1, 1'b0, 1'b0, 0, 1'b0, a1);
    check("b2b_spacing_lat2", a1 - a0, 16 * 3 + 3);

    // Randomized blocks
    for (int i = 0; i < 6; i++) begin
      k = int'($urandom_range(0, 1));
      run_block(k, 1'(($urandom % 2)), 1'(($urandom % 2)),
                int'($urandom_range(0, 3)), 1'b0, a0);
    end

    // Reset while round 7 is being committed (decrypt, so mode reset is visible)
    @(negedge clk);
    in_valid[0]   = 1'b1;
    in_decrypt[0] = 1'b1;
    out_ready[0]  = 1'b1;
    #1;
    check("rst_mid_accept", load_en[0], 1);
    for (int d = 1; d <= 8; d++) begin
      @(negedge clk);
      in_valid[0] = 1'b0;
      #1;
    end
    check("rst_mid_round_idx", round_idx[0], 7);
    check("rst_mid_round_en", round_en[0], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle(0);
    check("rst_mid_round_idx_clr", round_idx[0], 0);
    check("rst_mid_shift_dir", shift_dir[0], 0);
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      #1;
      check("post_rst_round_en", round_en[0], 0);
      check("post_rst_final_en", final_en[0], 0);
      check("post_rst_busy", busy[0], 0);
    end
    run_block(0, 1'b0, 1'b0, 0, 1'b0, a0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
